mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised multiply/divide unit for the pipelined CPU, sitting beside the ALU in the E stage and owning the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU as multi-cycle operations with a start/busy handshake, and MTHI/MTLO as single-cycle writes. Latencies and width are configurable. A cancel input lets exception/flush logic abort an in-flight operation without disturbing HI/LO.

## Interface
- WIDTH, 32, operand and HI/LO width
- MUL_LAT, 5, cycles from accepted multiply to HI/LO update (>=1)
- DIV_LAT, 10, cycles from accepted divide to HI/LO update (>=1)

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  request: launch op with a, b this cycle
- op  in  3  operation code from the shared package
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
- b  in  WIDTH  rt operand (divisor / multiplier)
- cancel  in  1  abort in-flight op (exception flush)
- busy  out  1  multi-cycle op in progress
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

## Operation
- States: IDLE, RUN. Reset -> IDLE, busy=0, hi=0, lo=0, counter=0.
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}: latch a, b, op; counter <= MUL_LAT or DIV_LAT; -> RUN.
- IDLE, start=1, op=MTHI: hi <= a at that edge; stay IDLE. MTLO likewise for lo. No busy.
- RUN: counter decrements each cycle; at counter==1 edge write hi/lo from latched operands, -> IDLE.
- start while RUN (busy=1): ignored entirely; hazard unit is responsible for stalling.
- Unknown op with start: ignored, no state change.
- cancel=1: RUN -> IDLE at next edge, hi/lo unchanged; in IDLE, any start that cycle is suppressed (cancel wins).
- Arithmetic: MULT signed, MULTU unsigned; {hi,lo} = 2*WIDTH-bit product.
- DIV signed: lo = quotient truncated toward zero, hi = remainder with dividend's sign. DIVU unsigned.
- Divisor zero: hi/lo unchanged, full DIV_LAT busy period still taken.
- Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
- hi/lo are plain registers; readers (MFHI/MFLO) sample them directly; no forwarding inside this block.

## Timing
- Start accepted at edge T: busy=1 from T through T+LAT-1 (exactly LAT cycles high); hi/lo updated and busy=0 at edge T+LAT.
- Back-to-back: new start may be presented in the cycle busy first reads 0; accepted same edge.
- LAT=1: busy high one cycle; hi/lo visible after edge T+1.
- MTHI/MTLO: write visible the cycle after the start edge.
- cancel at edge T+k (k<LAT): busy=0 after that edge, hi/lo hold pre-op values.
- reset asserted mid-RUN: busy, hi, lo drop to 0 immediately (asynchronous), no completion write.

## Structure
- Package mdu_pkg: op encodings (MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5), state enum, helper function for latency selection.
- Sub-module mdu_arith: purely combinational, takes latched op/a/b, returns next hi/lo including div-zero and overflow rules; top holds FSM, counter, operand latches, HI/LO.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT))+1.

## Test plan
- MULT a=-3 (0xFFFFFFFD), b=7, default params -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> busy 10 cycles, then lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0; DIV by b=0 after MTHI 0x1234/MTLO 0x5678 -> hi/lo stay 0x1234/0x5678 after 10 busy cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, cancel asserted on 3rd busy cycle -> busy=0 next edge, hi/lo unchanged; start during busy (DIVU 9/3) ignored.
- Async reset pulse mid-DIV -> busy, hi, lo 0 without a clock edge; re-run with MUL_LAT=1, DIV_LAT=1 -> each op completes after one busy cycle, back-to-back starts accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state and latency helpers
// for the E-stage multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_e;

    function automatic logic mdu_is_multi(logic [2:0] op);
        return op <= 3'(MDU_DIVU);
    endfunction

    function automatic int mdu_lat(
        logic [2:0] op,
        int mul_lat,
        int div_lat
    );
        if (op == 3'(MDU_DIV) || op == 3'(MDU_DIVU))
            return div_lat;
        return mul_lat;
    endfunction

    function automatic int mdu_max(int x, int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: start/busy request bundle between the E stage
// and the multiply/divide unit, plus the HI/LO read path.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational HI/LO result for a latched op,
// holding the current values on divide-by-zero.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_cur,
    input  logic [WIDTH-1:0] lo_cur,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    localparam logic [WIDTH-1:0] MIN_NEG =
        {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]        ua, ub, uprod;
    logic signed [2*WIDTH-1:0] sa2, sb2, sprod;
    logic signed [WIDTH-1:0]   sa, sb;
    logic                      is_mult, is_multu;
    logic                      is_div, is_divu;

    assign is_mult  = (op == 3'(MDU_MULT));
    assign is_multu = (op == 3'(MDU_MULTU));
    assign is_div   = (op == 3'(MDU_DIV));
    assign is_divu  = (op == 3'(MDU_DIVU));

    assign sa    = $signed(a);
    assign sb    = $signed(b);
    assign ua    = {{WIDTH{1'b0}}, a};
    assign ub    = {{WIDTH{1'b0}}, b};
    assign sa2   = $signed({{WIDTH{a[WIDTH-1]}}, a});
    assign sb2   = $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uprod = ua * ub;
    assign sprod = sa2 * sb2;

    always_comb begin
        hi_nxt = hi_cur;
        lo_nxt = lo_cur;
        unique case (1'b1)
            is_mult: begin
                {hi_nxt, lo_nxt} = sprod;
            end
            is_multu: begin
                {hi_nxt, lo_nxt} = uprod;
            end
            is_div: begin
                if (b == '0) begin
                    hi_nxt = hi_cur;
                end else if (a == MIN_NEG && b == '1) begin
                    // quotient does not fit; wrap to the dividend
                    lo_nxt = a;
                    hi_nxt = '0;
                end else begin
                    lo_nxt = sa / sb;
                    hi_nxt = sa % sb;
                end
            end
            is_divu: begin
                if (b != '0) begin
                    lo_nxt = a / b;
                    hi_nxt = a % b;
                end
            end
            default: begin
                hi_nxt = hi_cur;
            end
        endcase
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/DIV engine owning HI/LO,
// with single-cycle MTHI/MTLO and flush cancel.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    localparam int MAXL = mdu_max(MUL_LAT, DIV_LAT);
    localparam int CW   = $clog2(MAXL) + 1;

    mdu_state_e       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             latch;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_cur (hi_q),
        .lo_cur (lo_q),
        .hi_nxt (res_hi),
        .lo_nxt (res_lo)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hi_d    = hi_q;
        lo_d    = lo_q;
        latch   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    if (mdu_is_multi(bus.op)) begin
                        latch   = 1'b1;
                        cnt_d   = CW'(mdu_lat(bus.op, MUL_LAT, DIV_LAT));
                        state_d = ST_RUN;
                    end else if (bus.op == 3'(MDU_MTHI)) begin
                        hi_d = bus.a;
                    end else if (bus.op == 3'(MDU_MTLO)) begin
                        lo_d = bus.a;
                    end
                end
            end
            ST_RUN: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt == CW'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (latch) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for default latencies
// and a second instance with both latencies set to 1.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) m0 ();
    mdu_if #(.WIDTH(32)) m1 ();

    mul_div_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (m0.slave)
    );

    mul_div_unit #(.WIDTH(32), .MUL_LAT(1), .DIV_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (m1.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue0(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        m0.start = 1'b1;
        m0.op    = op;
        m0.a     = a;
        m0.b     = b;
        step();
        m0.start = 1'b0;
    endtask

    task automatic wait_idle0(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!m0.busy) break;
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        if (m0.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", m0.busy); end
        vecs++;
        if (m0.hi !== 32'h0) begin errs++; $display("FAIL rst_hi got %h want 0", m0.hi); end
        vecs++;
        if (m0.lo !== 32'h0) begin errs++; $display("FAIL rst_lo got %h want 0", m0.lo); end
        vecs++;
    endtask

    task automatic test_mult();
        int n;
        issue0(3'(MDU_MULT), 32'hFFFF_FFFD, 32'd7);
        wait_idle0(n);
        if (n !== 5) begin errs++; $display("FAIL mult_lat got %0d want 5", n); end
        vecs++;
        if (m0.hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mult_hi got %h want ffffffff", m0.hi); end
        vecs++;
        if (m0.lo !== 32'hFFFF_FFEB) begin errs++; $display("FAIL mult_lo got %h want ffffffeb", m0.lo); end
        vecs++;
    endtask

    task automatic test_div();
        int n;
        issue0(3'(MDU_DIVU), 32'd100, 32'd7);
        wait_idle0(n);
        if (n !== 10) begin errs++; $display("FAIL divu_lat got %0d want 10", n); end
        vecs++;
        if (m0.lo !== 32'd14) begin errs++; $display("FAIL divu_lo got %h want e", m0.lo); end
        vecs++;
        if (m0.hi !== 32'd2) begin errs++; $display("FAIL divu_hi got %h want 2", m0.hi); end
        vecs++;
        issue0(3'(MDU_DIV), 32'hFFFF_FFF9, 32'd2);
        wait_idle0(n);
        if (m0.lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_lo got %h want fffffffd", m0.lo); end
        vecs++;
        if (m0.hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div_hi got %h want ffffffff", m0.hi); end
        vecs++;
    endtask

    task automatic test_overflow();
        int n;
        issue0(3'(MDU_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle0(n);
        if (m0.lo !== 32'h8000_0000) begin errs++; $display("FAIL ovf_lo got %h want 80000000", m0.lo); end
        vecs++;
        if (m0.hi !== 32'h0) begin errs++; $display("FAIL ovf_hi got %h want 0", m0.hi); end
        vecs++;
    endtask

    task automatic test_div_zero();
        int n;
        issue0(3'(MDU_MTHI), 32'h1234, 32'h0);
        if (m0.busy !== 1'b0) begin errs++; $display("FAIL mthi_busy got %b want 0", m0.busy); end
        vecs++;
        if (m0.hi !== 32'h1234) begin errs++; $display("FAIL mthi_hi got %h want 1234", m0.hi); end
        vecs++;
        issue0(3'(MDU_MTLO), 32'h5678, 32'h0);
        if (m0.lo !== 32'h5678) begin errs++; $display("FAIL mtlo_lo got %h want 5678", m0.lo); end
        vecs++;
        issue0(3'(MDU_DIV), 32'd5, 32'd0);
        wait_idle0(n);
        if (n !== 10) begin errs++; $display("FAIL dz_lat got %0d want 10", n); end
        vecs++;
        if (m0.hi !== 32'h1234) begin errs++; $display("FAIL dz_hi got %h want 1234", m0.hi); end
        vecs++;
        if (m0.lo !== 32'h5678) begin errs++; $display("FAIL dz_lo got %h want 5678", m0.lo); end
        vecs++;
    endtask

    task automatic test_cancel();
        int n;
        issue0(3'(MDU_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        step();
        m0.cancel = 1'b1;
        step();
        m0.cancel = 1'b0;
        if (m0.busy !== 1'b0) begin errs++; $display("FAIL cxl_busy got %b want 0", m0.busy); end
        vecs++;
        if (m0.hi !== 32'h1234) begin errs++; $display("FAIL cxl_hi got %h want 1234", m0.hi); end
        vecs++;
        if (m0.lo !== 32'h5678) begin errs++; $display("FAIL cxl_lo got %h want 5678", m0.lo); end
        vecs++;
        m0.cancel = 1'b1;
        issue0(3'(MDU_MTHI), 32'hDEAD, 32'h0);
        m0.cancel = 1'b0;
        if (m0.hi !== 32'h1234) begin errs++; $display("FAIL cxl_idle_hi got %h want 1234", m0.hi); end
        vecs++;
    endtask

    task automatic test_start_busy();
        int n;
        issue0(3'(MDU_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue0(3'(MDU_DIVU), 32'd9, 32'd3);
        wait_idle0(n);
        if (n !== 4) begin errs++; $display("FAIL sb_lat got %0d want 4", n); end
        vecs++;
        if (m0.hi !== 32'hFFFF_FFFE) begin errs++; $display("FAIL sb_hi got %h want fffffffe", m0.hi); end
        vecs++;
        if (m0.lo !== 32'h0000_0001) begin errs++; $display("FAIL sb_lo got %h want 1", m0.lo); end
        vecs++;
        step();
        if (m0.busy !== 1'b0) begin errs++; $display("FAIL sb_noq got %b want 0", m0.busy); end
        vecs++;
    endtask

    task automatic test_async_reset();
        issue0(3'(MDU_DIVU), 32'd100, 32'd7);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        if (m0.busy !== 1'b0) begin errs++; $display("FAIL ar_busy got %b want 0", m0.busy); end
        vecs++;
        if (m0.hi !== 32'h0) begin errs++; $display("FAIL ar_hi got %h want 0", m0.hi); end
        vecs++;
        if (m0.lo !== 32'h0) begin errs++; $display("FAIL ar_lo got %h want 0", m0.lo); end
        vecs++;
        step();
        reset = 1'b1;
        repeat (12) step();
        if (m0.lo !== 32'h0) begin errs++; $display("FAIL ar_nowr got %h want 0", m0.lo); end
        vecs++;
    endtask

    task automatic test_back_to_back();
        m1.start = 1'b1;
        m1.op    = 3'(MDU_MULT);
        m1.a     = 32'hFFFF_FFFD;
        m1.b     = 32'd7;
        step();
        m1.start = 1'b0;
        if (m1.busy !== 1'b1) begin errs++; $display("FAIL l1_busy got %b want 1", m1.busy); end
        vecs++;
        step();
        if (m1.busy !== 1'b0) begin errs++; $display("FAIL l1_done got %b want 0", m1.busy); end
        vecs++;
        if (m1.lo !== 32'hFFFF_FFEB) begin errs++; $display("FAIL l1_mlo got %h want ffffffeb", m1.lo); end
        vecs++;
        m1.start = 1'b1;
        m1.op    = 3'(MDU_DIVU);
        m1.a     = 32'd100;
        m1.b     = 32'd7;
        step();
        m1.start = 1'b0;
        if (m1.busy !== 1'b1) begin errs++; $display("FAIL b2b_busy got %b want 1", m1.busy); end
        vecs++;
        step();
        if (m1.lo !== 32'd14) begin errs++; $display("FAIL b2b_lo got %h want e", m1.lo); end
        vecs++;
        if (m1.hi !== 32'd2) begin errs++; $display("FAIL b2b_hi got %h want 2", m1.hi); end
        vecs++;
    endtask

    initial begin
        m0.start = 1'b0; m0.op = '0; m0.a = '0; m0.b = '0; m0.cancel = 1'b0;
        m1.start = 1'b0; m1.op = '0; m1.a = '0; m1.b = '0; m1.cancel = 1'b0;
        #12;
        test_reset();
        reset = 1'b1;
        step();
        test_mult();
        test_div();
        test_overflow();
        test_div_zero();
        test_cancel();
        test_start_busy();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
